csa_stream_accumulator: RTL and testbench

Streaming multi-operand accumulator that keeps its running sum in carry-save form and resolves it to binary only at packet end. It is the sequential successor of the CSA 3:2 compressor: each accepted beat folds NUM_OPS operands into registered carry/sum vectors through a chain of 3:2 compressors. A chunked carry-propagate adder resolves the result over several cycles. It sits in the MSM datapath wherever long sums of wide partial products must be reduced without a full-width carry chain on the critical path.

---
 rtl/csa_stream_accumulator.sv | 139 +++++++++++++
 tb/tb_csa_stream_accumulator.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator
// Streaming multi-operand accumulator. The running sum is kept in carry-save
// form (S, C) so each beat only costs NUM_OPS levels of 3:2 compression. At
// packet end a chunked carry-propagate adder resolves S + C to binary, CHUNK
// bits per cycle, and the result is offered on a valid/ready output port.
module csa_stream_accumulator #(
  parameter int DATA_SIZE = 32,
  parameter int NUM_OPS   = 3,
  parameter int CHUNK     = 16,
  parameter int BEAT_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  input  logic [NUM_OPS*2*DATA_SIZE-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*DATA_SIZE-1:0]      out_data,
  output logic [BEAT_W-1:0]           out_beats
);

  localparam int W   = 2 * DATA_SIZE;
  localparam int NCH = W / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCH - 1);

  typedef enum logic [1:0] {ACC, RES, OUT} state_t;

  state_t            state;
  logic [W-1:0]      s_q;
  logic [W-1:0]      c_q;
  logic [BEAT_W-1:0] beat_cnt;
  logic [CW-1:0]     chunk_idx;
  logic              carry_q;

  logic [W-1:0]      s_nxt;
  logic [W-1:0]      c_nxt;
  logic [W-1:0]      op_w;
  logic [W-1:0]      maj_w;
  logic [CHUNK:0]    chunk_sum;
  logic              in_fire;
  logic              out_fire;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_beats = beat_cnt;

  // Fold the beat's operands into the carry-save pair through a 3:2 chain.
  always_comb begin
    // NOTE: every variable written here gets a value before any branch or
    // loop reads it, so no path leaves it unassigned and no latch is inferred.
    s_nxt = s_q;
    c_nxt = c_q;
    op_w  = '0;
    maj_w = '0;
    for (int j = 0; j < NUM_OPS; j++) begin
      op_w  = in_data[j*W +: W];
      maj_w = (s_nxt & c_nxt) | (s_nxt & op_w) | (c_nxt & op_w);
      s_nxt = s_nxt ^ c_nxt ^ op_w;
      // Carry moves up one weight; the carry out of the MSB is dropped (mod 2^W).
      c_nxt = {maj_w[W-2:0], 1'b0};
    end
  end

  // One CHUNK-bit slice of the final carry-propagate addition.
  always_comb begin
    chunk_sum = {1'b0, s_q[chunk_idx*CHUNK +: CHUNK]}
              + {1'b0, c_q[chunk_idx*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
  end

  // Control FSM with registered handshake outputs and the datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      s_q       <= '0;
      c_q       <= '0;
      beat_cnt  <= '0;
      chunk_idx <= '0;
      carry_q   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order within this block.
      case (state)
        ACC: begin
          if (in_fire) begin
            s_q <= s_nxt;
            c_q <= c_nxt;
            if (beat_cnt != '1) begin
              beat_cnt <= beat_cnt + 1'b1;
            end
            if (in_last) begin
              state     <= RES;
              chunk_idx <= '0;
              carry_q   <= 1'b0;
              in_ready  <= 1'b0;
            end
          end
        end

        RES: begin
          out_data[chunk_idx*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry_q <= chunk_sum[CHUNK];
          if (chunk_idx == LAST_CHUNK) begin
            // Final carry-out is discarded: the result is modulo 2^W.
            chunk_idx <= '0;
            state     <= OUT;
            out_valid <= 1'b1;
          end else begin
            chunk_idx <= chunk_idx + 1'b1;
          end
        end

        OUT: begin
          if (out_fire) begin
            s_q       <= '0;
            c_q       <= '0;
            beat_cnt  <= '0;
            state     <= ACC;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= ACC;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Bench for csa_stream_accumulator with W=16, NCH=4, BEAT_W=2.
// A reference model sums operands modulo 2^W and counts saturating beats;
// expected packets are queued when the last beat is accepted and compared
// by a monitor whenever the DUT hands a result over.
module tb_csa_stream_accumulator;

  localparam int DATA_SIZE = 8;
  localparam int NUM_OPS   = 3;
  localparam int CHUNK     = 4;
  localparam int BEAT_W    = 2;
  localparam int W         = 2 * DATA_SIZE;
  localparam int NCH       = W / CHUNK;
  localparam int MAX_BEATS = (1 << BEAT_W) - 1;

  typedef struct {
    logic [W-1:0]      data;
    logic [BEAT_W-1:0] beats;
  } exp_t;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [NUM_OPS*W-1:0]  in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [W-1:0]          out_data;
  logic [BEAT_W-1:0]     out_beats;

  exp_t         exp_q[$];
  logic [W-1:0] m_acc;
  int           m_beats;
  int           checks;
  int           bad;

  csa_stream_accumulator #(
    .DATA_SIZE(DATA_SIZE),
    .NUM_OPS  (NUM_OPS),
    .CHUNK    (CHUNK),
    .BEAT_W   (BEAT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_beats(out_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: compare each result the DUT is about to hand over.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got data=%h beats=%0d, expected no output", out_data, out_beats);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_data !== e.data || out_beats !== e.beats) begin
          bad++;
          $display("FAIL result: got data=%h beats=%0d, expected data=%h beats=%0d",
                   out_data, out_beats, e.data, e.beats);
        end
      end
    end
  end

  task automatic model_clear();
    m_acc   = '0;
    m_beats = 0;
  endtask

  // Offer one beat, wait for acceptance, and update the reference model.
  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                      input logic last, input logic must_be_ready);
    int n;
    exp_t e;
    n        = 0;
    in_valid = 1'b1;
    in_data  = {c, b, a};
    in_last  = last;
    @(negedge clk);
    if (must_be_ready) begin
      checks++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL in_ready_during_beats: got %b, expected 1", in_ready);
      end
    end
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      bad++;
      $display("FAIL beat_accept_timeout: got in_ready=%b after %0d cycles, expected 1", in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    m_acc    = m_acc + a + b + c;
    if (m_beats < MAX_BEATS) m_beats++;
    if (last) begin
      e.data  = m_acc;
      e.beats = BEAT_W'(m_beats);
      exp_q.push_back(e);
      model_clear();
    end
  endtask

  // Accept results until the scoreboard is empty; then in_ready must be back.
  task automatic drain(input string name);
    int n;
    n         = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 100) begin
      bad++;
      $display("FAIL %s_drain_timeout: got %0d pending results, expected 0", name, exp_q.size());
    end else if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready_after_result: got in_ready=%b, expected 1", name, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_clear();
    #12;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || out_beats !== '0) begin
      bad++;
      $display("FAIL reset_state: got valid=%b ready=%b data=%h beats=%0d, expected 0 1 0000 0",
               out_valid, in_ready, out_data, out_beats);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    out_ready = 1'b0;
    beat(16'd1, 16'd2, 16'd3, 1'b1, 1'b1);
    for (int i = 0; i <= NCH; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (i == NCH)) begin
        bad++;
        $display("FAIL latency_cycle%0d: got out_valid=%b, expected %b", i, out_valid, (i == NCH));
      end
    end
    drain("latency");
  endtask

  task automatic test_wrap();
    beat(16'hFFFF, 16'hFFFF, 16'h0002, 1'b1, 1'b1);
    drain("wrap");
  endtask

  task automatic test_back_to_back();
    beat(16'h1000, 16'h2000, 16'h0100, 1'b0, 1'b1);
    beat(16'h1000, 16'h2000, 16'h0100, 1'b0, 1'b1);
    beat(16'h1000, 16'h2000, 16'h0100, 1'b1, 1'b1);
    drain("back_to_back");
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    beat(16'h1000, 16'h2000, 16'h0100, 1'b0, 1'b1);
    beat(16'h1000, 16'h2000, 16'h0100, 1'b0, 1'b1);
    beat(16'h1000, 16'h2000, 16'h0100, 1'b1, 1'b1);
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_last  = 1'b1;
      in_data  = {$urandom, $urandom};
      @(negedge clk);
      checks++;
      if (exp_q.size() != 1) begin
        bad++;
        $display("FAIL hold_queue: got %0d pending, expected 1", exp_q.size());
      end else if (out_valid !== 1'b1 || out_data !== exp_q[0].data ||
                   out_beats !== exp_q[0].beats || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_cycle%0d: got valid=%b data=%h beats=%0d ready=%b, expected 1 %h %0d 0",
                 i, out_valid, out_data, out_beats, in_ready, exp_q[0].data, exp_q[0].beats);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    drain("backpressure");
    beat(16'd5, 16'd0, 16'd0, 1'b1, 1'b1);
    drain("after_backpressure");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      beat(16'd1, 16'd0, 16'd0, (i == 4), 1'b1);
    end
    drain("saturation");
  endtask

  task automatic test_reset_mid_res();
    out_ready = 1'b1;
    beat(16'd9, 16'd9, 16'd9, 1'b1, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_beats !== '0) begin
      bad++;
      $display("FAIL reset_mid_res: got valid=%b ready=%b beats=%0d, expected 0 1 0",
               out_valid, in_ready, out_beats);
    end
    exp_q.delete();
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < NCH + 2; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL aborted_packet_cycle%0d: got out_valid=%b, expected 0", i, out_valid);
      end
    end
    @(posedge clk);
    #1;
    beat(16'd7, 16'd0, 16'd0, 1'b1, 1'b1);
    drain("after_reset");
  endtask

  initial begin
    checks = 0;
    bad    = 0;
    test_reset();
    test_latency();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_reset_mid_res();
    checks++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_results: got %0d pending, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule
